host_console_arbiter: RTL and testbench
=======================================

HOST_CONSOLE_ARBITER -- requirements
Module: host_console_arbiter

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, sets shared FIFO depth to 2**DEPTH_LOG2 entries.
REQ-002 clk  input  1  single system clock; all state on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in0_data  input  8  byte from console source 0, valid while in0_strobe high.
REQ-005 in0_strobe  input  1  source 0 byte-ready level; stays high until that source's next byte starts.
REQ-006 in1_data  input  8  byte from console source 1.
REQ-007 in1_strobe  input  1  source 1 byte-ready level; same semantics as in0_strobe.
REQ-008 out_valid  output  1  FIFO head entry is available.
REQ-009 out_data  output  8  FIFO head byte; show-ahead.
REQ-010 out_src  output  1  source id of the head byte.
REQ-011 out_ack  input  1  IO controller pops the head entry.
REQ-012 out_count  output  DEPTH_LOG2+1  current FIFO occupancy.
REQ-013 ovf  output  2  sticky per-source overflow flags; bit i belongs to source i.
REQ-014 ovf_clr  input  1  clears both ovf bits.

Function
REQ-015 Each source shall be edge-detected: a byte event occurs in cycle N when inX_strobe is sampled high in N and was low in N-1; inX_data is captured in that same cycle.
REQ-016 A byte event shall load a per-source holding register and set its hold_valid flag at the end of cycle N.
REQ-017 If a byte event hits a holding register that is valid and not granted in that cycle, the new byte shall be dropped, the held byte kept, and ovf[i] set.
REQ-018 If the holding register is granted in the same cycle as a new byte event, the new byte shall be loaded and ovf shall not be set.
REQ-019 The arbiter shall grant at most one holding register per cycle, and only when the FIFO can accept a write (count below depth, or a pop in the same cycle).
REQ-020 With both holding registers valid, the arbiter shall grant the source not granted last (round-robin); the last-grant pointer resets to 1 so source 0 wins first.
REQ-021 A grant shall write {src, data} into the FIFO and clear that hold_valid in the same cycle.
REQ-022 Latency: an event in cycle N with an idle FIFO gives a grant in N+1; out_valid is high from N+2.
REQ-023 out_valid = (count != 0); out_data and out_src shall reflect the entry at the read pointer with no added cycle.
REQ-024 out_ack while out_valid is low shall be ignored, with no pointer or count change.
REQ-025 A simultaneous push and pop shall leave count unchanged, including at full and at count = 1.
REQ-026 Read and write pointers shall be DEPTH_LOG2 bits and wrap modulo depth; count shall saturate neither up nor down, by construction.
REQ-027 When the FIFO is full and not popping, holding registers shall retain their data; further events on a valid holding register follow REQ-017.
REQ-028 ovf[i] set and ovf_clr in the same cycle: set shall win.

Reset
REQ-029 Reset shall clear both hold_valid flags, both pointers, count, and ovf, giving out_valid=0, out_count=0, ovf=2'b00.
REQ-030 Reset shall set both strobe-history registers to 1, so a strobe already high at reset release generates no event; reset mid-operation shall discard all queued and held bytes.
REQ-031 out_data and out_src are don't-care while out_valid=0; the storage array is not reset.

Structure
REQ-032 Package host_console_pkg shall hold: the DEPTH_LOG2 default, the entry width constant (9), and the source-id constants SRC_CON0=0 and SRC_CON1=1.
REQ-033 The FIFO shall be one sub-module, host_console_fifo (storage, pointers, count, show-ahead read); edge detect, holding registers, arbitration and overflow stay in the top.

Verification
REQ-034 Single byte: in0_strobe rises with 0x41 at cycle N -> out_valid=1 from N+2 with out_data=0x41, out_src=0; out_ack -> out_count=0.
REQ-035 Simultaneous rises: in0 0x11 and in1 0x22 in the same cycle -> FIFO order 0x11/src0, then 0x22/src1; the next simultaneous pair is also served in round-robin order.
REQ-036 Held strobe: in0_strobe held high for 1000 cycles -> exactly one entry; strobe high through reset release -> zero entries.
REQ-037 Fill: 16 bytes, no ack -> out_count=16; 17th on src1 held; 18th on src1 -> ovf=2'b10; one ack -> held byte enters, count stays 16.
REQ-038 Full push+pop: count=16, ack together with a pending grant -> count 16, order preserved; ovf_clr together with a new overflow -> ovf stays set.
REQ-039 Reset mid-stream with count=5 -> out_valid=0, out_count=0, ovf=0 in the next cycle; post-reset bytes arrive normally.

Source files
------------

// File: rtl/host_console_arbiter_pkg.sv
// ============================================================================
// host_console_pkg : shared constants and entry type for the console arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package host_console_pkg;
  localparam int   DEPTH_LOG2_DEFAULT = 4;
  localparam int   ENTRY_W            = 9;
  localparam logic SRC_CON0           = 1'b0;
  localparam logic SRC_CON1           = 1'b1;

  typedef struct packed {
    logic       src;
    logic [7:0] data;
  } entry_t;
endpackage

`default_nettype wire

// File: rtl/host_console_arbiter_if.sv
// ============================================================================
// host_console_arbiter_if : console sources, IO-controller pop side, overflow
// Revision: 1.0
// ============================================================================
`default_nettype none

interface host_console_arbiter_if
  import host_console_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) ();
  logic [7:0]          in0_data;
  logic                in0_strobe;
  logic [7:0]          in1_data;
  logic                in1_strobe;
  logic                out_valid;
  logic [7:0]          out_data;
  logic                out_src;
  logic                out_ack;
  logic [DEPTH_LOG2:0] out_count;
  logic [1:0]          ovf;
  logic                ovf_clr;

  modport master (
    output in0_data, in0_strobe, in1_data, in1_strobe, out_ack, ovf_clr,
    input  out_valid, out_data, out_src, out_count, ovf
  );

  modport slave (
    input  in0_data, in0_strobe, in1_data, in1_strobe, out_ack, ovf_clr,
    output out_valid, out_data, out_src, out_count, ovf
  );
endinterface

`default_nettype wire

// File: rtl/host_console_arbiter_fifo.sv
// ============================================================================
// host_console_fifo : show-ahead FIFO with occupancy count
// Revision: 1.0
// ============================================================================
`default_nettype none

module host_console_fifo
  import host_console_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic                i_push,
  input  wire logic [ENTRY_W-1:0]  i_wdata,
  input  wire logic                i_pop,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic [ENTRY_W-1:0]       o_rdata,
  output logic [DEPTH_LOG2:0]      o_count
);
  localparam int                  c_depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_full  = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [ENTRY_W-1:0]    r_mem [c_depth];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_pop;
  logic                  w_push;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_pop   = i_pop && (r_count != '0);
  assign o_ready = (r_count != c_full) || w_pop;
  assign w_push  = i_push && o_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

`default_nettype wire

// File: rtl/host_console_arbiter.sv
// ============================================================================
// host_console_arbiter : merges two strobed console byte sources into one FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

module host_console_arbiter
  import host_console_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  wire logic              clk,
  input  wire logic              reset,
  host_console_arbiter_if.slave  bus
);
  logic [1:0] w_strobe;
  logic [7:0] w_in_data [2];
  logic [1:0] r_strb_hist;
  logic [1:0] w_evt;
  logic [1:0] r_hold_valid;
  logic [7:0] r_hold_data [2];
  logic [1:0] w_grant;
  logic [1:0] w_ovf_set;
  logic [1:0] w_load;
  logic [1:0] r_ovf;
  logic       r_last_grant;
  logic       w_fifo_ready;
  logic       w_fifo_valid;
  entry_t     w_wdata;
  entry_t     w_rdata;

  assign w_strobe     = {bus.in1_strobe, bus.in0_strobe};
  assign w_in_data[0] = bus.in0_data;
  assign w_in_data[1] = bus.in1_data;

  // History resets high so a strobe already asserted at release is not an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_strb_hist <= 2'b11;
    else       r_strb_hist <= w_strobe;
  end

  assign w_evt = w_strobe & ~r_strb_hist;

  always_comb begin
    w_grant = 2'b00;
    if (w_fifo_ready) begin
      if (r_hold_valid == 2'b11) w_grant = r_last_grant ? 2'b01 : 2'b10;
      else                       w_grant = r_hold_valid;
    end
  end

  always_comb begin
    w_wdata.src  = SRC_CON0;
    w_wdata.data = r_hold_data[0];
    if (w_grant[1]) begin
      w_wdata.src  = SRC_CON1;
      w_wdata.data = r_hold_data[1];
    end
  end

  assign w_ovf_set = w_evt & r_hold_valid & ~w_grant;
  assign w_load    = w_evt & ~w_ovf_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_valid <= 2'b00;
      r_last_grant <= 1'b1;
      r_ovf        <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_load[i])       r_hold_valid[i] <= 1'b1;
        else if (w_grant[i]) r_hold_valid[i] <= 1'b0;
      end
      if (|w_grant) r_last_grant <= w_grant[1];
      r_ovf <= (bus.ovf_clr ? 2'b00 : r_ovf) | w_ovf_set;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_load[i]) r_hold_data[i] <= w_in_data[i];
    end
  end

  host_console_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (|w_grant),
    .i_wdata (w_wdata),
    .i_pop   (bus.out_ack),
    .o_ready (w_fifo_ready),
    .o_valid (w_fifo_valid),
    .o_rdata (w_rdata),
    .o_count (bus.out_count)
  );

  assign bus.out_valid = w_fifo_valid;
  assign bus.out_data  = w_rdata.data;
  assign bus.out_src   = w_rdata.src;
  assign bus.ovf       = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_host_console_arbiter.sv
// ============================================================================
// tb_host_console_arbiter : vector table, corner sequences and random traffic
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_host_console_arbiter;
  import host_console_pkg::*;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  host_console_arbiter_if #(.DEPTH_LOG2(DL)) bus ();

  host_console_arbiter #(.DEPTH_LOG2(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of {src,data}, one holding slot per source.
  logic [8:0] mq[$];
  logic       m_hv   [2];
  logic [7:0] m_hd   [2];
  logic       m_hist [2];
  int         m_last;
  logic [1:0] m_ovf;

  function automatic void m_reset();
    mq.delete();
    for (int i = 0; i < 2; i++) begin
      m_hv[i]   = 1'b0;
      m_hist[i] = 1'b1;
    end
    m_last = 1;
    m_ovf  = 2'b00;
  endfunction

  function automatic void m_step();
    logic       s  [2];
    logic [7:0] d  [2];
    logic       ev [2];
    bit         pop;
    bit         canw;
    int         g;
    s[0] = bus.in0_strobe; d[0] = bus.in0_data;
    s[1] = bus.in1_strobe; d[1] = bus.in1_data;
    for (int i = 0; i < 2; i++) ev[i] = s[i] && !m_hist[i];
    pop  = bus.out_ack && (mq.size() > 0);
    canw = (mq.size() < DEPTH) || pop;
    g = -1;
    if (canw) begin
      if (m_hv[0] && m_hv[1]) g = 1 - m_last;
      else if (m_hv[0])       g = 0;
      else if (m_hv[1])       g = 1;
    end
    if (pop) void'(mq.pop_front());
    if (g >= 0) begin
      mq.push_back({g[0], m_hd[g]});
      m_hv[g] = 1'b0;
      m_last  = g;
    end
    if (bus.ovf_clr) m_ovf = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (ev[i]) begin
        if (m_hv[i]) m_ovf[i] = 1'b1;
        else begin
          m_hd[i] = d[i];
          m_hv[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 2; i++) m_hist[i] = s[i];
  endfunction

  function automatic void chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  function automatic void chk_model();
    logic [8:0] want_head;
    bit         ok;
    want_head = (mq.size() > 0) ? mq[0] : 9'h000;
    ok = (bus.out_valid == (mq.size() > 0)) && (int'(bus.out_count) == mq.size())
         && (bus.ovf == m_ovf)
         && ((mq.size() == 0) || ({bus.out_src, bus.out_data} == want_head));
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL model @%0t: got v=%0b cnt=%0d ovf=%b head=%h, expected v=%0b cnt=%0d ovf=%b head=%h",
               $time, bus.out_valid, bus.out_count, bus.ovf, {bus.out_src, bus.out_data},
               mq.size() > 0, mq.size(), m_ovf, want_head);
    end
  endfunction

  task automatic cyc();
    m_step();
    @(posedge clk);
    #1;
    chk_model();
  endtask

  task automatic set_in(input logic s0, input logic [7:0] d0, input logic s1,
                        input logic [7:0] d1, input logic ack, input logic clr);
    bus.in0_strobe = s0; bus.in0_data = d0;
    bus.in1_strobe = s1; bus.in1_data = d1;
    bus.out_ack    = ack; bus.ovf_clr = clr;
  endtask

  typedef struct {
    logic       s0;
    logic [7:0] d0;
    logic       s1;
    logic [7:0] d1;
    logic       ack;
    logic       clr;
    logic       ev;
    logic [7:0] edata;
    logic       esrc;
    int         ecnt;
    logic [1:0] eovf;
  } vec_t;

  vec_t       tbl [15];
  logic [8:0] exp_drain [16];

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 2'b00};
    tbl[1]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 2'b00};
    tbl[2]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1, 2'b00};
    tbl[3]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 2, 2'b00};
    tbl[4]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1, 2'b00};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 2'b00};
    tbl[6]  = '{1'b1, 8'h33, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 2'b00};
    tbl[7]  = '{1'b1, 8'h33, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1, 2'b00};
    tbl[8]  = '{1'b1, 8'h33, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 2, 2'b00};
    tbl[9]  = '{1'b1, 8'h33, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 1, 2'b00};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 2'b00};
    tbl[11] = '{1'b1, 8'h41, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0, 2'b00};
    tbl[12] = '{1'b1, 8'h41, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1, 2'b00};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 2'b00};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 2'b00};

    for (int i = 0; i < 14; i++) exp_drain[i] = {1'b0, 8'h82 + 8'(i)};
    exp_drain[14] = {1'b1, 8'hA1};
    exp_drain[15] = {1'b0, 8'hB0};

    // Reset state
    set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(bus.out_valid), 0);
    chk("reset_count", int'(bus.out_count), 0);
    chk("reset_ovf",   int'(bus.ovf), 0);
    reset = 1'b0;
    m_reset();

    // Vector table: simultaneous pairs, single byte, ack on empty
    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].s0, tbl[i].d0, tbl[i].s1, tbl[i].d1, tbl[i].ack, tbl[i].clr);
      cyc();
      chk($sformatf("vec%0d_valid", i), int'(bus.out_valid), int'(tbl[i].ev));
      chk($sformatf("vec%0d_count", i), int'(bus.out_count), tbl[i].ecnt);
      chk($sformatf("vec%0d_ovf", i),   int'(bus.ovf), int'(tbl[i].eovf));
      if (tbl[i].ev)
        chk($sformatf("vec%0d_head", i), int'({bus.out_src, bus.out_data}),
            int'({tbl[i].esrc, tbl[i].edata}));
    end

    // Strobe held high for 1000 cycles yields one entry
    set_in(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (1000) cyc();
    chk("held_count", int'(bus.out_count), 1);
    set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc();

    // Strobe high through reset release yields nothing
    set_in(1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
    repeat (10) cyc();
    chk("rst_held_count", int'(bus.out_count), 0);
    set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc();

    // Fill to 16, then held and dropped bytes on source 1
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 8'h80 + 8'(i), 1'b0, 8'h00, 1'b0, 1'b0);
      cyc();
      set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      cyc();
    end
    chk("fill_count", int'(bus.out_count), 16);
    set_in(1'b0, 8'h00, 1'b1, 8'hA1, 1'b0, 1'b0);
    cyc();
    set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc();
    chk("b17_ovf", int'(bus.ovf), 0);
    set_in(1'b0, 8'h00, 1'b1, 8'hA2, 1'b0, 1'b0);
    cyc();
    chk("b18_ovf", int'(bus.ovf), 2);
    set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc();
    chk("full_pushpop_count", int'(bus.out_count), 16);
    chk("full_pushpop_head",  int'({bus.out_src, bus.out_data}), 9'h081);

    // Pending grant at full, then clear racing a new overflow
    set_in(1'b1, 8'hB0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc();
    set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc();
    set_in(1'b1, 8'hB1, 1'b0, 8'h00, 1'b0, 1'b1);
    cyc();
    chk("clr_vs_set_ovf", int'(bus.ovf), 1);
    set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc();
    chk("full_ack_grant_count", int'(bus.out_count), 16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d", k), int'({bus.out_src, bus.out_data}), int'(exp_drain[k]));
      cyc();
    end
    chk("drain_count", int'(bus.out_count), 0);
    set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc();

    // Reset in the middle of a stream of 5 queued bytes
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 8'h00, 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      cyc();
      set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      cyc();
    end
    chk("pre_rst_count", int'(bus.out_count), 5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_count", int'(bus.out_count), 0);
    chk("mid_rst_ovf",   int'(bus.ovf), 0);
    reset = 1'b0;
    m_reset();
    cyc();
    set_in(1'b1, 8'hD5, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc();
    set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc();
    chk("post_rst_head",  int'({bus.out_src, bus.out_data}), 9'h0D5);
    chk("post_rst_count", int'(bus.out_count), 1);
    set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc();

    // Random traffic in phases of light and heavy draining
    for (int n = 0; n < 4000; n++) begin
      int ack_mod;
      ack_mod = ((n / 500) % 2 == 0) ? 2 : 6;
      if ($urandom_range(2) == 0) begin
        bus.in0_strobe = ~bus.in0_strobe;
        if (bus.in0_strobe) bus.in0_data = 8'($urandom);
      end
      if ($urandom_range(2) == 0) begin
        bus.in1_strobe = ~bus.in1_strobe;
        if (bus.in1_strobe) bus.in1_data = 8'($urandom);
      end
      bus.out_ack = ($urandom_range(ack_mod - 1) == 0);
      bus.ovf_clr = ($urandom_range(15) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
